// File: rtl/des_perm_queue_if.sv
// des_perm_queue_if: handshake bundle for des_perm_queue.
//   Input side : in_valid, in_ready, in_mode, in_data[64*LANES-1:0]
//   Output side: out_valid, out_ready, out_mode, out_data[64*LANES-1:0]
//   master drives the input side and consumes the output side; slave is the queue.
interface des_perm_queue_if #(
  parameter int unsigned LANES = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [64*LANES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_mode;
  logic [64*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
endinterface

// File: rtl/des_perm_queue.sv
// des_perm_queue: DES IP / IP^-1 bit permutation over LANES 64-bit blocks per
// beat, followed by a DEPTH-entry FIFO with valid/ready on both sides.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   flush   - synchronous queue clear (wins over push/pop)
//   bus     - des_perm_queue_if.slave (input beat / head entry handshakes)
//   level   - current occupancy, 0..DEPTH
//   chk_err - sticky round-trip self-check error
// Optional feature: define DES_PERM_SELFCHECK_EN to store the unpermuted input
// per entry and verify out_data against it on every pop; otherwise chk_err = 0.
module des_perm_queue #(
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  des_perm_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   chk_err
);

  localparam int unsigned DW = 64 * LANES;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  // Single 64-bit DES permutation; DES bit i lives at vector index 64-i.
  // IP:    T = first-row value of row r (58,60,62,64,57,59,61,63) minus 8*col.
  // IP^-1: T = first-row value of col c (40,8,48,16,56,24,64,32) minus row.
  function automatic logic [63:0] perm64(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    int r;
    int c;
    int t;
    y = '0;
    for (int i = 1; i <= 64; i++) begin
      r = (i - 1) / 8;
      c = (i - 1) % 8;
      if (!inv) t = ((r < 4) ? (58 + 2 * r) : (49 + 2 * r)) - 8 * c;
      else      t = (((c % 2) == 0) ? (40 + 8 * (c / 2)) : (8 + 8 * (c / 2))) - r;
      y[6'(64 - i)] = x[6'(64 - t)];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] perm_lanes(input logic [DW-1:0] x, input logic inv);
    logic [DW-1:0] y;
    y = '0;
    for (int k = 0; k < int'(LANES); k++) y[64*k +: 64] = perm64(x[64*k +: 64], inv);
    return y;
  endfunction

  logic [DW-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] mode_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic in_ready_q, out_valid_q;
  logic push, pop;
  logic [DW-1:0] perm_c;

  assign push   = bus.in_valid && in_ready_q;
  assign pop    = out_valid_q && bus.out_ready;
  assign perm_c = perm_lanes(bus.in_data, bus.in_mode);

  // Pointer / occupancy next state; flush overrides any push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push) tail_d = PW'(tail_q + 1'b1);
      if (pop)  head_d = PW'(head_q + 1'b1);
      case ({push, pop})
        2'b10:   level_d = LW'(level_q + 1'b1);
        2'b01:   level_d = LW'(level_q - 1'b1);
        default: level_d = level_q;
      endcase
    end
  end

  // Storage and handshake flags; flags are precomputed from level_d so they are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      mode_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      in_ready_q  <= (level_d != LW'(DEPTH));
      out_valid_q <= (level_d != '0);
      if (push && !flush) begin
        mem_q[tail_q]  <= perm_c;
        mode_q[tail_q] <= bus.in_mode;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = mem_q[head_q];
  assign bus.out_mode  = mode_q[head_q];
  assign level         = level_q;

`ifdef DES_PERM_SELFCHECK_EN
  logic [DW-1:0] orig_q [DEPTH];
  logic chk_err_q;
  logic mis_c;

  // Undo the head's permutation and compare against the stored raw input per lane.
  always_comb begin
    mis_c = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (perm64(bus.out_data[64*k +: 64], !bus.out_mode) != orig_q[head_q][64*k +: 64])
        mis_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) orig_q[i] <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (push && !flush) orig_q[tail_q] <= bus.in_data;
      if (pop && !flush && mis_c) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
